// File: rtl/program_fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, addresses the program ROM and feeds a
// 2-entry prefetch queue to the decoder over a valid/ready handshake.
module program_fetch_sequencer #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 4,
  parameter int RESET_PC   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  halt_i,
  input  logic                  redirect_i,
  input  logic [ADDR_WIDTH-1:0] redirect_addr_i,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [DATA_WIDTH-1:0] rom_data_i,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0] instr_pc_o,
  output logic                  instr_valid_o,
  input  logic                  instr_ready_i,
  output logic                  running_o
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  localparam logic [ADDR_WIDTH-1:0] PC_RST = ADDR_WIDTH'(RESET_PC);
  localparam logic [ADDR_WIDTH-1:0] PC_ONE = ADDR_WIDTH'(1);

  logic [0:0]            state_r, state_s;
  logic [ADDR_WIDTH-1:0] pc_r, pc_s;

  // Queue head drives the outputs directly; tail is the second slot.
  logic                  head_v_r, head_v_s;
  logic [DATA_WIDTH-1:0] head_op_r, head_op_s;
  logic [ADDR_WIDTH-1:0] head_pc_r, head_pc_s;
  logic                  tail_v_r, tail_v_s;
  logic [DATA_WIDTH-1:0] tail_op_r, tail_op_s;
  logic [ADDR_WIDTH-1:0] tail_pc_r, tail_pc_s;

  logic pop_s;
  logic full_s;
  logic fetch_s;

  assign pop_s   = head_v_r & instr_ready_i;
  assign full_s  = head_v_r & tail_v_r;
  assign fetch_s = (state_r == ST_RUN) & ~redirect_i & (~full_s | pop_s);

  assign rom_addr_o    = pc_r;
  assign instr_o       = head_op_r;
  assign instr_pc_o    = head_pc_r;
  assign instr_valid_o = head_v_r;
  assign running_o     = (state_r == ST_RUN);

  // Run/idle control; halt takes priority over start.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_i && !halt_i) state_s = ST_RUN;
        else                    state_s = ST_IDLE;
      end
      ST_RUN: begin
        if (halt_i) state_s = ST_IDLE;
        else        state_s = ST_RUN;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Program counter: redirect load beats sequential increment.
  always_comb begin
    pc_s = pc_r;
    if (redirect_i)   pc_s = redirect_addr_i;
    else if (fetch_s) pc_s = pc_r + PC_ONE;
    else              pc_s = pc_r;
  end

  // Queue update: flush, pop-and-shift, then append the fetched entry behind any survivor.
  always_comb begin
    head_v_s  = head_v_r;
    head_op_s = head_op_r;
    head_pc_s = head_pc_r;
    tail_v_s  = tail_v_r;
    tail_op_s = tail_op_r;
    tail_pc_s = tail_pc_r;
    if (redirect_i) begin
      head_v_s = 1'b0;
      tail_v_s = 1'b0;
    end else if (pop_s) begin
      if (tail_v_r) begin
        head_v_s  = 1'b1;
        head_op_s = tail_op_r;
        head_pc_s = tail_pc_r;
        tail_v_s  = fetch_s;
        if (fetch_s) begin
          tail_op_s = rom_data_i;
          tail_pc_s = pc_r;
        end else begin
          tail_op_s = tail_op_r;
        end
      end else begin
        head_v_s = fetch_s;
        if (fetch_s) begin
          head_op_s = rom_data_i;
          head_pc_s = pc_r;
        end else begin
          head_op_s = head_op_r;
        end
      end
    end else if (!head_v_r) begin
      head_v_s = fetch_s;
      if (fetch_s) begin
        head_op_s = rom_data_i;
        head_pc_s = pc_r;
      end else begin
        head_op_s = head_op_r;
      end
    end else if (!tail_v_r) begin
      tail_v_s = fetch_s;
      if (fetch_s) begin
        tail_op_s = rom_data_i;
        tail_pc_s = pc_r;
      end else begin
        tail_op_s = tail_op_r;
      end
    end else begin
      head_v_s = head_v_r;
    end
  end

  // State, PC and queue registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      pc_r      <= PC_RST;
      head_v_r  <= 1'b0;
      head_op_r <= {DATA_WIDTH{1'b0}};
      head_pc_r <= {ADDR_WIDTH{1'b0}};
      tail_v_r  <= 1'b0;
      tail_op_r <= {DATA_WIDTH{1'b0}};
      tail_pc_r <= {ADDR_WIDTH{1'b0}};
    end else begin
      state_r   <= state_s;
      pc_r      <= pc_s;
      head_v_r  <= head_v_s;
      head_op_r <= head_op_s;
      head_pc_r <= head_pc_s;
      tail_v_r  <= tail_v_s;
      tail_op_r <= tail_op_s;
      tail_pc_r <= tail_pc_s;
    end
  end

endmodule
